// File: rtl/instruction_encoder_pkg.sv
// Shared definitions for the instruction encoder: word layout, encoding,
// field legality and the loader FSM states.
package instruction_encoder_pkg;

    localparam int WORD_W = 16;

    // Bit positions of the 16-bit instruction word (shared with the decoder)
    localparam int MB_POS = 15;
    localparam int RW_POS = 14;   // holds ~RW
    localparam int MD_POS = 13;
    localparam int FS_HI  = 12;   // FS[3:1]
    localparam int FS_LO  = 10;
    localparam int CB_POS = 9;    // BC when PL, else FS[0]
    localparam int DA_HI  = 8;
    localparam int DA_LO  = 6;
    localparam int AA_HI  = 5;
    localparam int AA_LO  = 3;
    localparam int BA_HI  = 2;
    localparam int BA_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Pack the control-word fields into the instruction format
    function automatic logic [WORD_W-1:0] encode_word(
        input logic [2:0] da,
        input logic [2:0] aa,
        input logic [2:0] ba,
        input logic [3:0] fs,
        input logic       mb,
        input logic       md,
        input logic       rw,
        input logic       pl,
        input logic       bc
    );
        logic [WORD_W-1:0] w;
        w               = '0;
        w[MB_POS]       = mb;
        w[RW_POS]       = ~rw;
        w[MD_POS]       = md;
        w[FS_HI:FS_LO]  = fs[3:1];
        w[CB_POS]       = pl ? bc : fs[0];
        w[DA_HI:DA_LO]  = da;
        w[AA_HI:AA_LO]  = aa;
        w[BA_HI:BA_LO]  = ba;
        return w;
    endfunction

    // True when the decoder can regenerate every field from the encoded word
    function automatic logic fields_legal(
        input logic fs0,
        input logic mb,
        input logic md,
        input logic rw,
        input logic mw,
        input logic pl,
        input logic jb,
        input logic bc
    );
        logic ok;
        ok = (mw == (~rw & ~mb)) &&
             (pl == (~rw & mb))  &&
             (jb == md);
        if (pl)
            ok = ok && (fs0 == 1'b0);
        else
            ok = ok && (bc == fs0);
        return ok;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO holding encoded instruction words between the input
// handshake and the memory write stage. Head word is visible combinationally.
module inst_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW:0]       wptr;
    logic [PW:0]       rptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign rdata   = mem[rptr[PW-1:0]];

    // Pointer update; reset returns the FIFO to empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
        end
    end

    // Storage array; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instruction_encoder.sv
// Program-loader front end: encodes control-word fields, drops illegal
// combinations, buffers legal words and writes them to instruction memory
// at auto-incrementing addresses over a request/acknowledge handshake.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          STOP,
    input  logic [AW-1:0] BASE,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [2:0]    DA,
    input  logic [2:0]    AA,
    input  logic [2:0]    BA,
    input  logic [3:0]    FS,
    input  logic          MB,
    input  logic          MD,
    input  logic          RW,
    input  logic          MW,
    input  logic          PL,
    input  logic          JB,
    input  logic          BC,
    output logic          MEM_REQ,
    output logic [AW-1:0] MEM_ADDR,
    output logic [15:0]   MEM_DATA,
    input  logic          MEM_ACK,
    output logic          ILLEGAL,
    output logic [7:0]    ERR_CNT,
    output logic          DONE
);

    state_t            state;
    state_t            state_nxt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [WORD_W-1:0] fifo_head;
    logic [WORD_W-1:0] enc_word;
    logic              legal;
    logic              hs;
    logic              out_load;
    logic              sess_start;
    logic              drain_done;
    logic [AW-1:0]     addr_cnt;

    assign enc_word   = encode_word(DA, AA, BA, FS, MB, MD, RW, PL, BC);
    assign legal      = fields_legal(FS[0], MB, MD, RW, MW, PL, JB, BC);
    assign hs         = IN_VALID & IN_READY;
    assign fifo_push  = hs & legal;
    // The output register takes a new word whenever it is empty or being acked
    assign out_load   = (~MEM_REQ | MEM_ACK) & ~fifo_empty;
    assign fifo_pop   = out_load;
    assign sess_start = (state == ST_IDLE) & START;
    // Drain ends once nothing is buffered and the last request (if any) completes
    assign drain_done = (state == ST_DRAIN) & fifo_empty & (~MEM_REQ | MEM_ACK);

    inst_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (WORD_W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (enc_word),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and input-ready decode; ready looks only at full, so a pop
    // in the same cycle never admits a push into a full FIFO
    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START)
                    state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                IN_READY = ~fifo_full;
                if (STOP)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_done)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Memory write stage: request, address and data held until acknowledged
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            MEM_REQ  <= 1'b0;
            MEM_ADDR <= '0;
            MEM_DATA <= '0;
        end else if (out_load) begin
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= addr_cnt;
            MEM_DATA <= fifo_head;
        end else if (MEM_ACK) begin
            MEM_REQ  <= 1'b0;
        end
    end

    // Address counter: loads BASE at session start, advances per issued word
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            addr_cnt <= '0;
        else if (sess_start)
            addr_cnt <= BASE;
        else if (out_load)
            addr_cnt <= addr_cnt + 1'b1;
    end

    // Rejection pulse, saturating error count and drain-complete pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ILLEGAL <= 1'b0;
            ERR_CNT <= '0;
            DONE    <= 1'b0;
        end else begin
            ILLEGAL <= hs & ~legal;
            DONE    <= drain_done;
            if (sess_start)
                ERR_CNT <= '0;
            else if (hs && !legal && ERR_CNT != 8'hFF)
                ERR_CNT <= ERR_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder with a write scoreboard.
module tb_instruction_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          STOP = 1'b0;
    logic [AW-1:0] BASE = '0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [2:0]    DA = '0;
    logic [2:0]    AA = '0;
    logic [2:0]    BA = '0;
    logic [3:0]    FS = '0;
    logic          MB = 1'b0;
    logic          MD = 1'b0;
    logic          RW = 1'b0;
    logic          MW = 1'b0;
    logic          PL = 1'b0;
    logic          JB = 1'b0;
    logic          BC = 1'b0;
    logic          MEM_REQ;
    logic [AW-1:0] MEM_ADDR;
    logic [15:0]   MEM_DATA;
    logic          MEM_ACK = 1'b0;
    logic          ILLEGAL;
    logic [7:0]    ERR_CNT;
    logic          DONE;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int accepted = 0;
    int ill_cnt = 0;
    int done_cnt = 0;
    logic [AW+15:0] exp_q[$];
    logic [AW-1:0]  mcnt = '0;

    instruction_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .BASE(BASE),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .DA(DA), .AA(AA), .BA(BA), .FS(FS),
        .MB(MB), .MD(MD), .RW(RW), .MW(MW), .PL(PL), .JB(JB), .BC(BC),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_ACK(MEM_ACK),
        .ILLEGAL(ILLEGAL), .ERR_CNT(ERR_CNT), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_word();
        logic cb;
        cb = PL ? BC : FS[0];
        return {MB, ~RW, MD, FS[3:1], cb, DA, AA, BA};
    endfunction

    function automatic logic model_legal();
        logic ok;
        ok = (MW == (!RW && !MB)) && (PL == (!RW && MB)) && (JB == MD);
        if (PL) ok = ok && !FS[0];
        else    ok = ok && (BC == FS[0]);
        return ok;
    endfunction

    task automatic set_fields(input logic [2:0] da, input logic [2:0] aa, input logic [2:0] ba,
                              input logic [3:0] fs, input logic mb, input logic md, input logic rw,
                              input logic mw, input logic pl, input logic jb, input logic bc);
        DA = da; AA = aa; BA = ba; FS = fs;
        MB = mb; MD = md; RW = rw; MW = mw; PL = pl; JB = jb; BC = bc;
    endtask

    // Random legal field set covering ALU, store, branch and immediate forms
    task automatic set_random_legal();
        int kind;
        kind = $urandom_range(0, 3);
        DA = 3'($urandom); AA = 3'($urandom); BA = 3'($urandom);
        FS = 4'($urandom); MD = 1'($urandom); JB = MD;
        MB = kind[1]; RW = kind[0];
        MW = !RW && !MB;
        PL = !RW && MB;
        if (PL) begin FS[0] = 1'b0; BC = 1'($urandom); end
        else    BC = FS[0];
    endtask

    // Observe one cycle at the falling edge, then advance past the rising edge
    task automatic tick();
        logic [AW+15:0] e;
        @(negedge CLK);
        if (MEM_REQ && MEM_ACK) begin
            writes++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write observed addr 0x%0h data 0x%0h expected none", MEM_ADDR, MEM_DATA);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(MEM_ADDR), 32'(e[AW+15:16]));
                chk("wr_data", 32'(MEM_DATA), 32'(e[15:0]));
            end
        end
        if (IN_VALID && IN_READY) begin
            accepted++;
            if (model_legal()) begin
                exp_q.push_back({mcnt, model_word()});
                mcnt = mcnt + 1'b1;
            end
        end
        if (ILLEGAL) ill_cnt++;
        if (DONE) done_cnt++;
        @(posedge CLK);
        #1;
    endtask

    task automatic start_session(input logic [AW-1:0] base);
        BASE = base; START = 1'b1; mcnt = base;
        tick();
        START = 1'b0;
    endtask

    task automatic stop_and_wait_done(input string tag);
        int d0;
        int n;
        d0 = done_cnt; n = 0;
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        while (done_cnt == d0 && n < 40) begin tick(); n++; end
        chk(tag, 32'(done_cnt - d0), 32'd1);
        tick();
    endtask

    initial begin
        int w0;
        int a0;
        int d0;
        int n;

        // Reset values while reset is held
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready", 32'(IN_READY), 0);
        chk("rst_mem_req",  32'(MEM_REQ), 0);
        chk("rst_mem_addr", 32'(MEM_ADDR), 0);
        chk("rst_mem_data", 32'(MEM_DATA), 0);
        chk("rst_illegal",  32'(ILLEGAL), 0);
        chk("rst_err_cnt",  32'(ERR_CNT), 0);
        chk("rst_done",     32'(DONE), 0);
        RST = 1'b0;
        tick();
        chk("idle_in_ready", 32'(IN_READY), 0);

        // Session: illegal set, ALU op, branch op
        start_session(8'h10);
        chk("load_in_ready", 32'(IN_READY), 1);
        set_fields(3'd3, 3'd1, 3'd2, 4'b0101, 0, 0, 1, 1, 0, 0, 1);
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        chk("illegal_pulse", 32'(ILLEGAL), 1);
        chk("err_cnt_1", 32'(ERR_CNT), 1);
        tick();
        chk("illegal_once", 32'(ILLEGAL), 0);
        chk("illegal_no_req", 32'(MEM_REQ), 0);

        set_fields(3'd3, 3'd1, 3'd2, 4'b0101, 0, 0, 1, 0, 0, 0, 1);
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        chk("alu_latency_idle", 32'(MEM_REQ), 0);
        tick();
        chk("alu_req",  32'(MEM_REQ), 1);
        chk("alu_addr", 32'(MEM_ADDR), 32'h10);
        chk("alu_data", 32'(MEM_DATA), 32'h0ACA);

        set_fields(3'd0, 3'd5, 3'd3, 4'b0000, 1, 0, 0, 0, 1, 0, 1);
        IN_VALID = 1'b1;
        MEM_ACK = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        chk("br_req",  32'(MEM_REQ), 1);
        chk("br_addr", 32'(MEM_ADDR), 32'h11);
        chk("br_data", 32'(MEM_DATA), 32'hC22B);
        tick();
        chk("br_req_drop", 32'(MEM_REQ), 0);

        // Back-to-back words with ACK held high
        w0 = writes;
        IN_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_random_legal();
            tick();
        end
        IN_VALID = 1'b0;
        n = 0;
        while (MEM_REQ && n < 10) begin tick(); n++; end
        chk("stream_writes", 32'(writes - w0), 4);
        stop_and_wait_done("done_a");
        chk("ill_total", 32'(ill_cnt), 1);

        // Backpressure: six offered with ACK low
        start_session(8'h10);
        chk("err_cnt_cleared", 32'(ERR_CNT), 0);
        MEM_ACK = 1'b0;
        w0 = writes;
        a0 = accepted;
        set_random_legal();
        IN_VALID = 1'b1;
        repeat (10) begin
            n = accepted;
            tick();
            if (accepted != n) set_random_legal();
        end
        chk("bp_accepted", 32'(accepted - a0), 5);
        chk("bp_in_ready", 32'(IN_READY), 0);
        chk("bp_req_addr", 32'(MEM_ADDR), 32'h10);
        MEM_ACK = 1'b1;
        n = 0;
        while (accepted - a0 < 6 && n < 20) begin tick(); n++; end
        IN_VALID = 1'b0;
        n = 0;
        while ((MEM_REQ || exp_q.size() != 0) && n < 20) begin tick(); n++; end
        chk("bp_writes", 32'(writes - w0), 6);
        stop_and_wait_done("done_bp");

        // Address wrap
        start_session(8'hFE);
        w0 = writes;
        IN_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_random_legal();
            tick();
        end
        IN_VALID = 1'b0;
        n = 0;
        while (MEM_REQ && n < 10) begin tick(); n++; end
        chk("wrap_writes", 32'(writes - w0), 3);
        chk("wrap_last_addr", 32'(MEM_ADDR), 32'h00);
        stop_and_wait_done("done_wrap");

        // Drain with two words pending
        start_session(8'h30);
        chk("idle_after_done", 32'(IN_READY), 1);
        MEM_ACK = 1'b0;
        w0 = writes;
        IN_VALID = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_random_legal();
            tick();
        end
        IN_VALID = 1'b0;
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        chk("drain_in_ready", 32'(IN_READY), 0);
        d0 = done_cnt;
        MEM_ACK = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 20) begin tick(); n++; end
        tick();
        tick();
        chk("drain_done_once", 32'(done_cnt - d0), 1);
        chk("drain_writes", 32'(writes - w0), 2);

        // Reset during drain
        start_session(8'h40);
        chk("idle_after_drain", 32'(IN_READY), 1);
        MEM_ACK = 1'b0;
        IN_VALID = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_random_legal();
            tick();
        end
        IN_VALID = 1'b0;
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        chk("pre_rst_req", 32'(MEM_REQ), 1);
        #2 RST = 1'b1;
        #1;
        chk("rst_async_req", 32'(MEM_REQ), 0);
        chk("rst_async_ready", 32'(IN_READY), 0);
        exp_q.delete();
        @(posedge CLK);
        #1 RST = 1'b0;
        d0 = done_cnt;
        repeat (4) tick();
        chk("rst_no_done", 32'(done_cnt - d0), 0);
        start_session(8'h50);
        MEM_ACK = 1'b1;
        repeat (4) tick();
        chk("rst_fifo_empty", 32'(MEM_REQ), 0);
        stop_and_wait_done("done_post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
